// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults for the scoreboarded register file
package regfile_pkg;

  // Default geometry: 32 registers of 32 bits
  localparam int DEF_W = 32;
  localparam int DEF_N = 32;

endpackage : regfile_pkg

// File: rtl/regfile_sb_dffe_w.sv
// rtl/regfile_sb_dffe_w.sv - W-bit storage word with enable and synchronous clear
module dffe_w #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] data_d;
  logic [W-1:0] data_q;

  // Hold the stored word unless the write port targets this register
  always_comb begin
    data_d = data_q;
    if (en) begin
      data_d = d;
    end
  end

  // Clear has priority over any load
  always_ff @(posedge clk) begin
    if (clr) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule : dffe_w

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with two read ports, one write port and a pending scoreboard
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int N       = DEF_N,
  parameter int AW      = $clog2(N),
  parameter bit BYPASS  = 1'b1,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic          Clk,
  input  logic          Clr,
  input  logic          We,
  input  logic [AW-1:0] Wa,
  input  logic [W-1:0]  D,
  input  logic [AW-1:0] Ra,
  input  logic [AW-1:0] Rb,
  input  logic          ReA,
  input  logic          ReB,
  output logic [W-1:0]  Qa,
  output logic [W-1:0]  Qb,
  input  logic          Set,
  input  logic [AW-1:0] Sa,
  output logic          PA,
  output logic          PB,
  output logic          Stall,
  output logic [AW:0]   PendCnt
);

  logic [W-1:0] regs [N];
  logic [N-1:0] pend_d;
  logic [N-1:0] pend_q;
  logic [AW:0]  cnt_d;
  logic [AW:0]  cnt_q;
  logic         we_ok;
  logic         set_ok;
  logic         inc;
  logic         dec;

  // Writes and sets aimed at a hardwired r0 are discarded
  always_comb begin
    we_ok  = We  && !(ZERO_R0 && (Wa == '0));
    set_ok = Set && !(ZERO_R0 && (Sa == '0));
  end

  // Storage words; only the addressed word loads on a legal write
  for (genvar i = 0; i < N; i++) begin : g_reg
    dffe_w #(.W(W)) u_reg (
      .clk (Clk),
      .clr (Clr),
      .en  (we_ok && (Wa == AW'(i))),
      .d   (D),
      .q   (regs[i])
    );
  end

  // Next pending vector and incremental count; a set on the written index wins
  always_comb begin
    pend_d = pend_q;
    if (we_ok) begin
      pend_d[Wa] = 1'b0;
    end
    if (set_ok) begin
      pend_d[Sa] = 1'b1;
    end
    inc   = set_ok && !pend_q[Sa];
    dec   = we_ok && pend_q[Wa] && !(set_ok && (Sa == Wa));
    cnt_d = cnt_q + (AW+1)'(inc) - (AW+1)'(dec);
  end

  // Scoreboard state; clear drops every outstanding pending bit
  always_ff @(posedge Clk) begin
    if (Clr) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  // Read port A: stored value, forwarded write data, or hardwired zero
  always_comb begin
    Qa = regs[Ra];
    PA = pend_q[Ra];
    if (BYPASS && we_ok && (Wa == Ra)) begin
      Qa = D;
      PA = 1'b0;
    end
    if (ZERO_R0 && (Ra == '0)) begin
      Qa = '0;
      PA = 1'b0;
    end
  end

  // Read port B: same selection as port A
  always_comb begin
    Qb = regs[Rb];
    PB = pend_q[Rb];
    if (BYPASS && we_ok && (Wa == Rb)) begin
      Qb = D;
      PB = 1'b0;
    end
    if (ZERO_R0 && (Rb == '0)) begin
      Qb = '0;
      PB = 1'b0;
    end
  end

  // Stall only when a source actually used by the instruction is pending
  always_comb begin
    Stall = (ReA && PA) || (ReB && PB);
  end

  assign PendCnt = cnt_q;

endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - scoreboard-driven directed bench for regfile_sb
module tb_regfile_sb;

  localparam int W  = 32;
  localparam int N  = 32;
  localparam int AW = 5;

  // Observation selectors: d = default, n = no bypass, z = r0 not hardwired
  localparam int S_QA_D = 0,  S_QB_D = 1,  S_PA_D = 2,  S_PB_D = 3,  S_ST_D = 4,  S_CN_D = 5;
  localparam int S_QA_N = 6,  S_PA_N = 7,  S_ST_N = 8,  S_CN_N = 9;
  localparam int S_QA_Z = 10, S_PA_Z = 11, S_CN_Z = 12;

  logic          Clk = 1'b0;
  logic          Clr, We, ReA, ReB, Set;
  logic [AW-1:0] Wa, Ra, Rb, Sa;
  logic [W-1:0]  D;

  logic [W-1:0] qa_d, qb_d, qa_n, qb_n, qa_z, qb_z;
  logic         pa_d, pb_d, st_d, pa_n, pb_n, st_n, pa_z, pb_z, st_z;
  logic [AW:0]  cn_d, cn_n, cn_z;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } item_t;

  item_t sb[$];
  int    errors = 0;
  int    checks = 0;

  always #5 Clk = ~Clk;

  regfile_sb #(.W(W), .N(N), .BYPASS(1'b1), .ZERO_R0(1'b1)) dut_d (
    .Clk(Clk), .Clr(Clr), .We(We), .Wa(Wa), .D(D), .Ra(Ra), .Rb(Rb), .ReA(ReA), .ReB(ReB),
    .Qa(qa_d), .Qb(qb_d), .Set(Set), .Sa(Sa), .PA(pa_d), .PB(pb_d), .Stall(st_d), .PendCnt(cn_d));

  regfile_sb #(.W(W), .N(N), .BYPASS(1'b0), .ZERO_R0(1'b1)) dut_n (
    .Clk(Clk), .Clr(Clr), .We(We), .Wa(Wa), .D(D), .Ra(Ra), .Rb(Rb), .ReA(ReA), .ReB(ReB),
    .Qa(qa_n), .Qb(qb_n), .Set(Set), .Sa(Sa), .PA(pa_n), .PB(pb_n), .Stall(st_n), .PendCnt(cn_n));

  regfile_sb #(.W(W), .N(N), .BYPASS(1'b1), .ZERO_R0(1'b0)) dut_z (
    .Clk(Clk), .Clr(Clr), .We(We), .Wa(Wa), .D(D), .Ra(Ra), .Rb(Rb), .ReA(ReA), .ReB(ReB),
    .Qa(qa_z), .Qb(qb_z), .Set(Set), .Sa(Sa), .PA(pa_z), .PB(pb_z), .Stall(st_z), .PendCnt(cn_z));

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      S_QA_D: return qa_d;
      S_QB_D: return qb_d;
      S_PA_D: return 32'(pa_d);
      S_PB_D: return 32'(pb_d);
      S_ST_D: return 32'(st_d);
      S_CN_D: return 32'(cn_d);
      S_QA_N: return qa_n;
      S_PA_N: return 32'(pa_n);
      S_ST_N: return 32'(st_n);
      S_CN_N: return 32'(cn_n);
      S_QA_Z: return qa_z;
      S_PA_Z: return 32'(pa_z);
      S_CN_Z: return 32'(cn_z);
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic expect_v(input string tag, input int sel, input logic [31:0] e);
    item_t it;
    it.tag = tag;
    it.sel = sel;
    it.exp = e;
    sb.push_back(it);
  endtask

  task automatic drain();
    item_t it;
    #1;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      checks++;
      assert (obs(it.sel) === it.exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", it.tag, obs(it.sel), it.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    Clr = 1'b0; We = 1'b0; Set = 1'b0; ReA = 1'b0; ReB = 1'b0;
    Wa = '0; Sa = '0; Ra = '0; Rb = '0; D = '0;
  endtask

  initial begin
    idle();
    Clr = 1'b1;
    tick();
    idle();

    // Reset state across every address
    for (int a = 0; a < N; a++) begin
      Ra = AW'(a);
      Rb = AW'(a);
      expect_v("rst_qa", S_QA_D, 32'h0);
      expect_v("rst_qb", S_QB_D, 32'h0);
      expect_v("rst_pa", S_PA_D, 32'h0);
      expect_v("rst_pb", S_PB_D, 32'h0);
      expect_v("rst_cnt", S_CN_D, 32'h0);
      drain();
    end

    // Set r5, then write it back with forwarding
    Set = 1'b1; Sa = 5'd5;
    tick();
    idle();
    Ra = 5'd5; ReA = 1'b1;
    expect_v("set5_pa", S_PA_D, 32'h1);
    expect_v("set5_stall", S_ST_D, 32'h1);
    expect_v("set5_cnt", S_CN_D, 32'h1);
    drain();
    We = 1'b1; Wa = 5'd5; D = 32'hDEADBEEF;
    expect_v("wb5_qa", S_QA_D, 32'hDEADBEEF);
    expect_v("wb5_pa", S_PA_D, 32'h0);
    expect_v("wb5_stall", S_ST_D, 32'h0);
    expect_v("wb5_nb_qa", S_QA_N, 32'h0);
    expect_v("wb5_nb_pa", S_PA_N, 32'h1);
    expect_v("wb5_nb_stall", S_ST_N, 32'h1);
    drain();
    tick();
    idle();
    Ra = 5'd5;
    expect_v("wb5_cnt", S_CN_D, 32'h0);
    expect_v("wb5_after_qa", S_QA_D, 32'hDEADBEEF);
    expect_v("wb5_nb_after_qa", S_QA_N, 32'hDEADBEEF);
    drain();

    // Same-cycle set and write to r7: set wins, data still stored
    Set = 1'b1; Sa = 5'd7; We = 1'b1; Wa = 5'd7; D = 32'h12345678;
    tick();
    idle();
    Ra = 5'd7;
    expect_v("sw7_pa", S_PA_D, 32'h1);
    expect_v("sw7_qa", S_QA_D, 32'h12345678);
    expect_v("sw7_cnt", S_CN_D, 32'h1);
    expect_v("sw7_stall_unused", S_ST_D, 32'h0);
    drain();
    Set = 1'b1; Sa = 5'd7;
    tick();
    idle();
    expect_v("reset7_cnt", S_CN_D, 32'h1);
    drain();
    We = 1'b1; Wa = 5'd7; D = 32'h0;
    tick();
    idle();
    expect_v("clr7_cnt", S_CN_D, 32'h0);
    drain();

    // Write and set aimed at r0
    We = 1'b1; Wa = 5'd0; D = 32'hFFFFFFFF; Set = 1'b1; Sa = 5'd0; Ra = 5'd0;
    expect_v("r0_qa_byp", S_QA_D, 32'h0);
    expect_v("r0_pa_byp", S_PA_D, 32'h0);
    expect_v("r0z_qa_byp", S_QA_Z, 32'hFFFFFFFF);
    drain();
    tick();
    idle();
    Ra = 5'd0;
    expect_v("r0_qa", S_QA_D, 32'h0);
    expect_v("r0_pa", S_PA_D, 32'h0);
    expect_v("r0_cnt", S_CN_D, 32'h0);
    expect_v("r0z_qa", S_QA_Z, 32'hFFFFFFFF);
    expect_v("r0z_pa", S_PA_Z, 32'h1);
    expect_v("r0z_cnt", S_CN_Z, 32'h1);
    drain();
    We = 1'b1; Wa = 5'd0; D = 32'hFFFFFFFF;
    tick();
    idle();
    expect_v("r0z_clr_cnt", S_CN_Z, 32'h0);
    drain();

    // Fill the scoreboard: registers 1..31 pending
    for (int a = 1; a < N; a++) begin
      Set = 1'b1; Sa = AW'(a);
      tick();
    end
    idle();
    Rb = 5'd31; ReB = 1'b1;
    expect_v("full_cnt", S_CN_D, 32'd31);
    expect_v("full_cnt_z", S_CN_Z, 32'd31);
    expect_v("full_pb", S_PB_D, 32'h1);
    expect_v("full_stall", S_ST_D, 32'h1);
    drain();
    Set = 1'b1; Sa = 5'd31;
    tick();
    idle();
    expect_v("full_reset_cnt", S_CN_D, 32'd31);
    drain();

    // Clear during a write: everything zero, write dropped
    Clr = 1'b1; We = 1'b1; Wa = 5'd9; D = 32'hAAAAAAAA; Set = 1'b1; Sa = 5'd2;
    tick();
    idle();
    Ra = 5'd9; Rb = 5'd5; ReA = 1'b1; ReB = 1'b1;
    expect_v("clr_cnt", S_CN_D, 32'h0);
    expect_v("clr_qa9", S_QA_D, 32'h0);
    expect_v("clr_pa9", S_PA_D, 32'h0);
    expect_v("clr_qb5", S_QB_D, 32'h0);
    expect_v("clr_stall", S_ST_D, 32'h0);
    drain();
    We = 1'b1; Wa = 5'd4; D = 32'h55;
    tick();
    idle();
    Ra = 5'd4;
    expect_v("postclr_cnt", S_CN_D, 32'h0);
    expect_v("postclr_qa4", S_QA_D, 32'h55);
    drain();

    // No bypass: old value during the write, new value next cycle
    We = 1'b1; Wa = 5'd3; D = 32'h11;
    tick();
    idle();
    We = 1'b1; Wa = 5'd3; D = 32'h33; Ra = 5'd3;
    expect_v("nb_old_qa", S_QA_N, 32'h11);
    expect_v("byp_new_qa", S_QA_D, 32'h33);
    drain();
    tick();
    idle();
    Ra = 5'd3;
    expect_v("nb_new_qa", S_QA_N, 32'h33);
    expect_v("nb_cnt", S_CN_N, 32'h0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_regfile_sb
